// File: rtl/add_seq_arb_if.sv
// Handshake bundle for add_seq_arb: two request ports and one result port.
// The master modport is the producer/consumer side, the slave modport is the arbiter.
interface add_seq_arb_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_c;
  logic             res_v;
  logic             res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  res_valid, res_sum, res_c, res_v, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output res_valid, res_sum, res_c, res_v, res_id,
    input  res_ready
  );
endinterface

// File: rtl/add_seq_arb.sv
// Two-requester round-robin add/subtract unit built on one shared 4-bit adder slice,
// run nibble-serially. Define ADDSEQ_SAT_EN to saturate res_sum on signed overflow.
module add_seq_arb #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  add_seq_arb_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             rr;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-5:0] sum_acc;
  logic             carry;
  logic [IW-1:0]    nib_idx;
  logic             id_reg;

  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_c;
  logic             res_v;
  logic             res_id;

  logic             grant_any;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_sum;
  logic [4:0]       c_chain;
  logic             last_nib;
  logic             v_flag;
  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] final_sum;

  // rr=0 means req0 wins a tie; a lone valid requester always wins.
  always_comb begin
    grant_any = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    grant_id  = (bus.req0_valid && bus.req1_valid) ? rr : bus.req1_valid;
    sel_a     = grant_id ? bus.req1_a   : bus.req0_a;
    sel_b     = grant_id ? bus.req1_b   : bus.req0_b;
    sel_sub   = grant_id ? bus.req1_sub : bus.req0_sub;
  end

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any &&  grant_id;

  // Shared 4-bit ripple slice fed by the nibble currently being processed.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (nib_idx == IW'(i)) begin
        nib_a = a_reg[4*i +: 4];
        nib_b = b_reg[4*i +: 4];
      end
    end
    c_chain[0] = carry;
    for (int j = 0; j < 4; j++) begin
      slice_sum[j]   = nib_a[j] ^ nib_b[j] ^ c_chain[j];
      c_chain[j+1]   = (nib_a[j] & nib_b[j]) | (c_chain[j] & (nib_a[j] ^ nib_b[j]));
    end
  end

  always_comb begin
    last_nib = (nib_idx == IW'(NIB - 1));
    v_flag   = c_chain[3] ^ c_chain[4];
    full_sum = {slice_sum, sum_acc};
`ifdef ADDSEQ_SAT_EN
    if (v_flag)
      final_sum = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      final_sum = full_sum;
`else
    final_sum = full_sum;
`endif
  end

  // B is stored pre-inverted with cin=sub so the slice only ever adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_acc   <= '0;
      carry     <= 1'b0;
      nib_idx   <= '0;
      id_reg    <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_c     <= 1'b0;
      res_v     <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_reg   <= sel_a;
            b_reg   <= sel_b ^ {WIDTH{sel_sub}};
            carry   <= sel_sub;
            id_reg  <= grant_id;
            rr      <= ~grant_id;
            nib_idx <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB - 1; i++) begin
            if (nib_idx == IW'(i))
              sum_acc[4*i +: 4] <= slice_sum;
          end
          carry <= c_chain[4];
          if (last_nib) begin
            res_sum   <= final_sum;
            res_c     <= c_chain[4];
            res_v     <= v_flag;
            res_id    <= id_reg;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            nib_idx <= nib_idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid;
  assign bus.res_sum   = res_sum;
  assign bus.res_c     = res_c;
  assign bus.res_v     = res_v;
  assign bus.res_id    = res_id;
endmodule

// File: tb/tb_add_seq_arb.sv
// Self-checking bench for add_seq_arb (WIDTH=16) using a plain-arithmetic reference model.
// Build with ADDSEQ_SAT_EN defined to check the saturating variant.
module tb_add_seq_arb;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  add_seq_arb_if #(.WIDTH(WIDTH)) bus ();

  add_seq_arb #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: sum/carry/overflow from integer arithmetic, result packed as {sum, c, v}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int ua, ub, sa, sb, r;
    logic [15:0] s;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      s = 16'(ua - ub);
      c = (ua >= ub);
      r = sa - sb;
    end else begin
      s = 16'(ua + ub);
      c = ((ua + ub) > 65535);
      r = sa + sb;
    end
    v = (r > 32767) || (r < -32768);
`ifdef ADDSEQ_SAT_EN
    if (v) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {s, c, v};
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners [4];
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic drive_idle();
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_sub   = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_sub   = 1'b0;
    bus.res_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one op on a single requester, scrambles its operands after accept,
  // and returns at the negedge where res_valid is first seen (lat=-1 on timeout).
  task automatic issue_op(input bit who, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, output logic ready_seen, output int lat);
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end
    #1;
    ready_seen = who ? (bus.req1_ready && !bus.req0_ready) : (bus.req0_ready && !bus.req1_ready);
    @(posedge clk);
    @(negedge clk);
    if (who) begin
      bus.req1_valid = 1'b0; bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_sub = ~sub;
    end else begin
      bus.req0_valid = 1'b0; bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_sub = ~sub;
    end
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.res_valid) lat = -1;
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    rst = 1'b1;
    drive_idle();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.res_valid, bus.res_sum, bus.res_c, bus.res_v, bus.res_id, bus.req0_ready, bus.req1_ready};
    checks++;
    if (got !== 21'd0) $display("[TB] FAIL reset_state: got %h expected %h", got, 21'd0);
    else passes++;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic rdy; int lat; logic [18:0] got;
    issue_op(1'b0, 16'h1234, 16'h4321, 1'b0, rdy, lat);
    checks++;
    if (rdy !== 1'b1) $display("[TB] FAIL add_ready: got %b expected 1", rdy);
    else passes++;
    checks++;
    if (lat != 5) $display("[TB] FAIL add_latency: got %0d expected 5", lat);
    else passes++;
    got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    checks++;
    if (got !== {16'h5555, 1'b0, 1'b0, 1'b0}) $display("[TB] FAIL add_result: got %h expected %h", got, {16'h5555, 3'b000});
    else passes++;
    consume();
    checks++;
    if (bus.res_valid !== 1'b0) $display("[TB] FAIL add_drop_valid: got %b expected 0", bus.res_valid);
    else passes++;
  endtask

  task automatic test_sub();
    logic rdy; int lat; logic [18:0] got;
    issue_op(1'b1, 16'h0005, 16'h0007, 1'b1, rdy, lat);
    got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    checks++;
    if (got !== {16'hFFFE, 1'b0, 1'b0, 1'b1}) $display("[TB] FAIL sub_borrow: got %h expected %h", got, {16'hFFFE, 3'b001});
    else passes++;
    consume();
    issue_op(1'b1, 16'h0007, 16'h0005, 1'b1, rdy, lat);
    got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    checks++;
    if (got !== {16'h0002, 1'b1, 1'b0, 1'b1}) $display("[TB] FAIL sub_no_borrow: got %h expected %h", got, {16'h0002, 3'b101});
    else passes++;
    consume();
  endtask

  task automatic test_overflow();
    logic rdy; int lat; logic [18:0] got; logic [15:0] exp1, exp2;
`ifdef ADDSEQ_SAT_EN
    exp1 = 16'h7FFF;
    exp2 = 16'h8000;
`else
    exp1 = 16'h8000;
    exp2 = 16'h7FFF;
`endif
    issue_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, rdy, lat);
    got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    checks++;
    if (got !== {exp1, 1'b0, 1'b1, 1'b0}) $display("[TB] FAIL ovf_add: got %h expected %h", got, {exp1, 3'b010});
    else passes++;
    consume();
    issue_op(1'b0, 16'h8000, 16'h0001, 1'b1, rdy, lat);
    got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    checks++;
    if (got !== {exp2, 1'b1, 1'b1, 1'b0}) $display("[TB] FAIL ovf_sub: got %h expected %h", got, {exp2, 3'b110});
    else passes++;
    consume();
  endtask

  task automatic test_arbitration();
    int seen = 0;
    int cyc = 0;
    int last_t = -1;
    logic exp_last = 1'b1;
    logic exp_id;
    logic [18:0] got, exp;
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0002; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h000A; bus.req1_b = 16'h0003; bus.req1_sub = 1'b1;
    bus.res_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (seen < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.res_valid) begin
        exp_id   = (seen < 4) ? ~exp_last : 1'b1;
        exp_last = exp_id;
        exp = exp_id ? {model(16'h000A, 16'h0003, 1'b1), 1'b1} : {model(16'h0001, 16'h0002, 1'b0), 1'b0};
        got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
        checks++;
        if (got !== exp) $display("[TB] FAIL arb_result_%0d: got %h expected %h", seen, got, exp);
        else passes++;
        if (last_t >= 0) begin
          checks++;
          if (cyc - last_t != 6) $display("[TB] FAIL arb_throughput_%0d: got %0d cycles expected 6", seen, cyc - last_t);
          else passes++;
        end
        last_t = cyc;
        seen++;
        if (seen == 4) bus.req0_valid = 1'b0;
      end
    end
    checks++;
    if (seen != 7) $display("[TB] FAIL arb_timeout: got %0d results expected 7", seen);
    else passes++;
    drive_idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic rdy; int lat; logic [20:0] got, exp; logic [18:0] rgot, rexp;
    do_reset();
    issue_op(1'b0, 16'hA5A5, 16'h1111, 1'b0, rdy, lat);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0F0F; bus.req0_b = 16'h0101; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h3000; bus.req1_b = 16'h1000; bus.req1_sub = 1'b1;
    exp = {1'b1, model(16'hA5A5, 16'h1111, 1'b0), 1'b0, 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {bus.res_valid, bus.res_sum, bus.res_c, bus.res_v, bus.res_id, bus.req0_ready, bus.req1_ready};
      checks++;
      if (got !== exp) $display("[TB] FAIL hold_%0d: got %h expected %h", k, got, exp);
      else passes++;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    got = {bus.res_valid, 18'd0, bus.req0_ready, bus.req1_ready};
    checks++;
    if (got !== {1'b0, 18'd0, 1'b0, 1'b1}) $display("[TB] FAIL release_rr: got %h expected %h", got, {1'b0, 18'd0, 2'b01});
    else passes++;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rgot = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    rexp = {model(16'h3000, 16'h1000, 1'b1), 1'b1};
    checks++;
    if (rgot !== rexp) $display("[TB] FAIL after_hold: got %h expected %h", rgot, rexp);
    else passes++;
    consume();
  endtask

  task automatic test_reset_mid_op();
    logic rdy; int lat; int stray; logic [2:0] got; logic [18:0] rgot;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    got = {bus.res_valid, bus.req0_ready, bus.req1_ready};
    checks++;
    if (got !== 3'b000) $display("[TB] FAIL rst_in_run: got %b expected 000", got);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid) stray++;
    end
    checks++;
    if (stray != 0) $display("[TB] FAIL rst_no_result: got %0d stray results expected 0", stray);
    else passes++;
    issue_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, rdy, lat);
    rgot = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
    checks++;
    if (rgot !== {16'h0000, 1'b1, 1'b0, 1'b0}) $display("[TB] FAIL wrap_after_rst: got %h expected %h", rgot, {16'h0000, 3'b100});
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0) $display("[TB] FAIL rst_in_done: got %b expected 0", bus.res_valid);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic rdy; int lat; bit who; logic [15:0] a, b; logic sub; logic [18:0] got, exp;
    for (int n = 0; n < 24; n++) begin
      who = 1'($urandom_range(0, 1));
      a   = pick_operand();
      b   = pick_operand();
      sub = 1'($urandom_range(0, 1));
      issue_op(who, a, b, sub, rdy, lat);
      exp = {model(a, b, sub), who};
      got = {bus.res_sum, bus.res_c, bus.res_v, bus.res_id};
      checks++;
      if (got !== exp || lat != 5 || rdy !== 1'b1)
        $display("[TB] FAIL random_%0d: a=%h b=%h sub=%b got %h lat=%0d rdy=%b expected %h lat=5 rdy=1", n, a, b, sub, got, lat, rdy, exp);
      else passes++;
      consume();
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_arbitration();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
